// File: rtl/alu_pkg.sv
// Shared ALU op encodings, flag and EX/MEM control types for the pipelined CPU.
// Both the ALU and the EX/MEM boundary import this so the op codes cannot drift apart.
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ex_mem_ctrl_t;

    function automatic logic op_is_defined(input logic [2:0] op);
        case (op)
            ALU_PASS_B, ALU_ADD, ALU_SUBTRACT,
            ALU_AND, ALU_OR, ALU_XOR: op_is_defined = 1'b1;
            default:                  op_is_defined = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        op_is_arith = (op == ALU_ADD) || (op == ALU_SUBTRACT);
    endfunction

    // Logical ops leave C/V architecturally cleared; the ALU's C/V for them are junk.
    function automatic nzcv_t flag_update(input logic [2:0] op, input nzcv_t alu_flags);
        nzcv_t f;
        f.n = alu_flags.n;
        f.z = alu_flags.z;
        f.c = op_is_arith(op) ? alu_flags.c : 1'b0;
        f.v = op_is_arith(op) ? alu_flags.v : 1'b0;
        flag_update = f;
    endfunction

endpackage

// File: rtl/nzcv_reg.sv
// Architectural NZCV register with the branch bypass view of the instruction in EX.
// A B.cond in decode reads br_flags, which already reflects a flag setter sitting in EX.
module nzcv_reg
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  logic       ex_valid,
    input  logic       ex_set_flags,
    input  logic [2:0] ex_cntrl,
    input  logic [3:0] ex_flags,
    output logic [3:0] flags,
    output logic [3:0] br_flags
);

    nzcv_t flag_q;
    nzcv_t flag_next;
    logic  setter_in_ex;
    logic  flag_we;

    assign flag_next    = flag_update(ex_cntrl, nzcv_t'(ex_flags));
    assign setter_in_ex = ex_valid & ex_set_flags & op_is_defined(ex_cntrl);
    assign flag_we      = setter_in_ex & ~stall & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q <= '0;
        end else if (flag_we) begin
            flag_q <= flag_next;
        end
    end

    // Bypass ignores stall/flush: the EX instruction is still older than the branch.
    assign flags    = flag_q;
    assign br_flags = setter_in_ex ? flag_next : flag_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX-to-MEM pipeline register: result, store data, destination and control bits.
// Flag state lives in nzcv_reg so the bypass logic stays next to the register it shadows.
module ex_mem_stage
    import alu_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic [2:0]          ex_cntrl,
    input  logic [WIDTH-1:0]    ex_result,
    input  logic                ex_negative,
    input  logic                ex_zero,
    input  logic                ex_overflow,
    input  logic                ex_carry_out,
    input  logic                ex_set_flags,
    input  logic [WIDTH-1:0]    ex_store_data,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_reg_write,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    output logic                mem_valid,
    output logic [WIDTH-1:0]    mem_result,
    output logic [WIDTH-1:0]    mem_store_data,
    output logic [REG_BITS-1:0] mem_rd,
    output logic                mem_reg_write,
    output logic                mem_mem_read,
    output logic                mem_mem_write,
    output logic                flag_n,
    output logic                flag_z,
    output logic                flag_c,
    output logic                flag_v,
    output logic                br_n,
    output logic                br_z,
    output logic                br_c,
    output logic                br_v
);

    ex_mem_ctrl_t        ctrl_q;
    ex_mem_ctrl_t        ctrl_d;
    logic [WIDTH-1:0]    result_q;
    logic [WIDTH-1:0]    store_q;
    logic [REG_BITS-1:0] rd_q;
    logic [3:0]          flags;
    logic [3:0]          br_flags;

    // Controls are gated by valid here so MEM never acts on a bubble's stale bits.
    always_comb begin
        ctrl_d           = '0;
        ctrl_d.valid     = ex_valid;
        ctrl_d.reg_write = ex_reg_write & ex_valid;
        ctrl_d.mem_read  = ex_mem_read  & ex_valid;
        ctrl_d.mem_write = ex_mem_write & ex_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
        end else if (flush) begin
            ctrl_q <= '0;
        end else if (!stall) begin
            ctrl_q   <= ctrl_d;
            result_q <= ex_result;
            store_q  <= ex_store_data;
            rd_q     <= ex_rd;
        end
    end

    nzcv_reg u_nzcv_reg (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_set_flags (ex_set_flags),
        .ex_cntrl     (ex_cntrl),
        .ex_flags     ({ex_negative, ex_zero, ex_carry_out, ex_overflow}),
        .flags        (flags),
        .br_flags     (br_flags)
    );

    assign mem_valid      = ctrl_q.valid;
    assign mem_reg_write  = ctrl_q.reg_write;
    assign mem_mem_read   = ctrl_q.mem_read;
    assign mem_mem_write  = ctrl_q.mem_write;
    assign mem_result     = result_q;
    assign mem_store_data = store_q;
    assign mem_rd         = rd_q;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;
    assign {br_n, br_z, br_c, br_v}         = br_flags;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: hand-computed vectors checked with immediate assertions.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic        ex_valid;
    logic [2:0]  ex_cntrl;
    logic [63:0] ex_result;
    logic        ex_negative, ex_zero, ex_overflow, ex_carry_out;
    logic        ex_set_flags;
    logic [63:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        mem_valid;
    logic [63:0] mem_result, mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        br_n, br_z, br_c, br_v;

    int vectors    = 0;
    int miscompares = 0;

    ex_mem_stage #(.WIDTH(64), .REG_BITS(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_cntrl(ex_cntrl), .ex_result(ex_result),
        .ex_negative(ex_negative), .ex_zero(ex_zero),
        .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out),
        .ex_set_flags(ex_set_flags), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .mem_valid(mem_valid), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .br_n(br_n), .br_z(br_z), .br_c(br_c), .br_v(br_v)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [2:0] op,
                                  input logic [63:0] res, input logic [3:0] nzcv,
                                  input logic sf, input logic [63:0] sd,
                                  input logic [4:0] rd, input logic rw,
                                  input logic mr, input logic mw);
        ex_valid      = v;
        ex_cntrl      = op;
        ex_result     = res;
        {ex_negative, ex_zero, ex_carry_out, ex_overflow} = nzcv;
        ex_set_flags  = sf;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
    endtask

    function automatic logic [3:0] flags_now();
        return {flag_n, flag_z, flag_c, flag_v};
    endfunction

    function automatic logic [3:0] br_now();
        return {br_n, br_z, br_c, br_v};
    endfunction

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        apply_stimulus(0, 3'b000, 64'h0, 4'h0, 0, 64'h0, 5'd0, 0, 0, 0);

        // Reset state
        #2;
        check_output("reset_mem_valid", {63'h0, mem_valid}, 64'h0);
        check_output("reset_flags", {60'h0, flags_now()}, 64'h0);
        check_output("reset_br", {60'h0, br_now()}, 64'h0);
        check_output("reset_mem_result", mem_result, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // ADDS 0x8000..+0x8000.. -> 0, N0 Z1 C1 V1
        @(negedge clk);
        apply_stimulus(1, 3'b010, 64'h0, 4'b0111, 1, 64'h0, 5'd1, 1, 0, 0);
        #1;
        check_output("adds_br_same_cycle", {60'h0, br_now()}, 64'h7);
        check_output("adds_flags_pre_edge", {60'h0, flags_now()}, 64'h0);
        edge_then_settle();
        check_output("adds_flags", {60'h0, flags_now()}, 64'h7);
        check_output("adds_mem_result", mem_result, 64'h0);
        check_output("adds_mem_valid", {63'h0, mem_valid}, 64'h1);

        // ANDS with junk C/V from the ALU -> C/V cleared
        @(negedge clk);
        apply_stimulus(1, 3'b100, 64'hFFFF_0000_0000_0001, 4'b1011, 1, 64'h0, 5'd2, 1, 0, 0);
        #1;
        check_output("ands_br", {60'h0, br_now()}, 64'h8);
        edge_then_settle();
        check_output("ands_flags", {60'h0, flags_now()}, 64'h8);
        check_output("ands_mem_result", mem_result, 64'hFFFF_0000_0000_0001);

        // Plain ADD: no flag write, bypass shows the register
        @(negedge clk);
        apply_stimulus(1, 3'b010, 64'h0000_8000_1A00_0000, 4'b1111, 0, 64'h0, 5'd3, 1, 0, 0);
        #1;
        check_output("add_br_eq_flags", {60'h0, br_now()}, 64'h8);
        edge_then_settle();
        check_output("add_mem_result", mem_result, 64'h0000_8000_1A00_0000);
        check_output("add_mem_rd", {59'h0, mem_rd}, 64'd3);
        check_output("add_mem_reg_write", {63'h0, mem_reg_write}, 64'h1);
        check_output("add_flags", {60'h0, flags_now()}, 64'h8);

        // SUBS 1-1 held by stall for three edges
        @(negedge clk);
        apply_stimulus(1, 3'b011, 64'h0, 4'b0110, 1, 64'h0, 5'd4, 1, 0, 0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output("subs_stall_br", {60'h0, br_now()}, 64'h6);
            edge_then_settle();
            check_output("subs_stall_flags", {60'h0, flags_now()}, 64'h8);
            check_output("subs_stall_result", mem_result, 64'h0000_8000_1A00_0000);
            check_output("subs_stall_rd", {59'h0, mem_rd}, 64'd3);
            @(negedge clk);
        end
        stall = 1'b0;
        edge_then_settle();
        check_output("subs_release_flags", {60'h0, flags_now()}, 64'h6);
        check_output("subs_release_valid", {63'h0, mem_valid}, 64'h1);
        check_output("subs_release_rd", {59'h0, mem_rd}, 64'd4);

        // Undefined op with set_flags: neither bypass nor write
        @(negedge clk);
        apply_stimulus(1, 3'b111, 64'h1234, 4'b1111, 1, 64'h0, 5'd5, 0, 0, 0);
        #1;
        check_output("undef_br", {60'h0, br_now()}, 64'h6);
        edge_then_settle();
        check_output("undef_flags", {60'h0, flags_now()}, 64'h6);
        check_output("undef_mem_result", mem_result, 64'h1234);

        // STUR with flush and stall together: bubble, no flag write, data held
        @(negedge clk);
        apply_stimulus(1, 3'b010, 64'h40, 4'b1111, 1, 64'hDEAD_BEEF_CAFE_F00D, 5'd6, 0, 0, 1);
        flush = 1'b1;
        stall = 1'b1;
        #1;
        check_output("flush_br_bypass", {60'h0, br_now()}, 64'hF);
        edge_then_settle();
        check_output("flush_mem_valid", {63'h0, mem_valid}, 64'h0);
        check_output("flush_mem_write", {63'h0, mem_mem_write}, 64'h0);
        check_output("flush_flags", {60'h0, flags_now()}, 64'h6);
        check_output("flush_result_hold", mem_result, 64'h1234);
        check_output("flush_store_hold", mem_store_data, 64'h0);

        // Same STUR captured normally
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;
        apply_stimulus(1, 3'b010, 64'h40, 4'b0000, 0, 64'hDEAD_BEEF_CAFE_F00D, 5'd6, 0, 0, 1);
        edge_then_settle();
        check_output("stur_mem_write", {63'h0, mem_mem_write}, 64'h1);
        check_output("stur_store_data", mem_store_data, 64'hDEAD_BEEF_CAFE_F00D);
        check_output("stur_mem_result", mem_result, 64'h40);

        // Invalid slot: controls gated, flag setter ignored
        @(negedge clk);
        apply_stimulus(0, 3'b010, 64'h99, 4'b1001, 1, 64'h0, 5'd7, 1, 1, 1);
        #1;
        check_output("invalid_br", {60'h0, br_now()}, 64'h6);
        edge_then_settle();
        check_output("invalid_mem_valid", {63'h0, mem_valid}, 64'h0);
        check_output("invalid_reg_write", {63'h0, mem_reg_write}, 64'h0);
        check_output("invalid_mem_read", {63'h0, mem_mem_read}, 64'h0);
        check_output("invalid_flags", {60'h0, flags_now()}, 64'h6);

        // Capture a load so there is state to clear
        @(negedge clk);
        apply_stimulus(1, 3'b010, 64'h77, 4'b1100, 1, 64'h5, 5'd9, 1, 1, 0);
        edge_then_settle();
        check_output("ld_mem_read", {63'h0, mem_mem_read}, 64'h1);
        check_output("ld_flags", {60'h0, flags_now()}, 64'hC);

        // Asynchronous reset between edges
        @(negedge clk);
        apply_stimulus(0, 3'b000, 64'h0, 4'h0, 0, 64'h0, 5'd0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_mem_valid", {63'h0, mem_valid}, 64'h0);
        check_output("async_mem_read", {63'h0, mem_mem_read}, 64'h0);
        check_output("async_mem_result", mem_result, 64'h0);
        check_output("async_store", mem_store_data, 64'h0);
        check_output("async_rd", {59'h0, mem_rd}, 64'h0);
        check_output("async_flags", {60'h0, flags_now()}, 64'h0);
        check_output("async_br", {60'h0, br_now()}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // First capture after reset
        apply_stimulus(1, 3'b010, 64'h0, 4'b0111, 1, 64'h0, 5'd1, 1, 0, 0);
        edge_then_settle();
        check_output("post_reset_flags", {60'h0, flags_now()}, 64'h7);
        check_output("post_reset_valid", {63'h0, mem_valid}, 64'h1);
        check_output("post_reset_rd", {59'h0, mem_rd}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline boundary of the pipelined CPU. Captures the 64-bit ALU result, store data and destination/control bits at the end of EX and presents them to MEM. Owns the architectural NZCV flag register, updated only by flag-setting instructions. Drives a bypassed flag view so a B.cond in decode sees flags from the instruction currently in EX.

## Interface
- WIDTH, 64: datapath width.
- REG_BITS, 5: register-index width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold all stage state this cycle.
- flush  in  1  replace captured instruction with a bubble; overrides stall.
- ex_valid  in  1  EX holds a real instruction.
- ex_cntrl  in  3  ALU op of the EX instruction (alu_pkg encodings).
- ex_result  in  WIDTH  ALU result.
- ex_negative, ex_zero, ex_overflow, ex_carry_out  in  1 each  ALU flags.
- ex_set_flags  in  1  instruction is ADDS/SUBS/ANDS-class.
- ex_store_data  in  WIDTH  data for STUR.
- ex_rd  in  REG_BITS  destination register.
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits.
- mem_valid  out  1  MEM holds a real instruction.
- mem_result, mem_store_data  out  WIDTH  registered copies.
- mem_rd  out  REG_BITS  registered destination.
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered, valid-gated controls.
- flag_n, flag_z, flag_c, flag_v  out  1 each  architectural NZCV register.
- br_n, br_z, br_c, br_v  out  1 each  bypassed flags for branch resolution.

## Operation
- Priority per edge: reset > flush > stall > normal capture.
- Normal capture: all mem_* data take ex_* values; mem_valid <= ex_valid; mem_reg_write/mem_mem_read/mem_mem_write <= ex_* AND ex_valid.
- Flush: mem_valid and the three mem control bits <= 0; mem_result/mem_store_data/mem_rd hold. NZCV unchanged.
- Stall (no flush): every register holds, including NZCV.
- Flag write enable = ex_valid & ex_set_flags & ~stall & ~flush.
- On flag write: N <= ex_negative, Z <= ex_zero.
  - ex_cntrl ADD (010) or SUBTRACT (011): C <= ex_carry_out, V <= ex_overflow.
  - ex_cntrl PASS_B/AND/OR/XOR: C <= 0, V <= 0 (ALU C/V are don't-care for these ops).
  - Undefined ex_cntrl (001, 111): no flag write.
- Bypass: when ex_valid & ex_set_flags & defined ex_cntrl, br_* equal the values NZCV would take (same C/V clearing rule). Otherwise br_* = flag_*. Bypass is independent of stall and flush: the EX instruction is still architecturally ahead of the branch.
- Subtract carry is ARM convention (carry = no borrow); the stage passes it unmodified.

## Timing
- Reset: mem_valid, all mem_* controls, mem_result, mem_store_data, mem_rd, and NZCV = 0. br_* follow the bypass rule from 0 registers.
- Reset mid-operation clears the stage immediately (asynchronous), independent of clk.
- Latency: ex_* to mem_* is exactly 1 cycle. ex flags to flag_* is 1 cycle. ex flags to br_* is 0 cycles (combinational).
- Stall held N cycles: outputs constant for N edges; capture resumes on the first edge with stall low.
- Flush and stall in the same cycle: bubble inserted; no flag write.
- Back-to-back flag setters: each edge writes the latest; br_* always reflect the current EX instruction.

## Structure
- alu_pkg holds:
  - ALU op constants ALU_PASS_B=000, ALU_ADD=010, ALU_SUBTRACT=011, ALU_AND=100, ALU_OR=101, ALU_XOR=110.
  - packed struct typedef nzcv_t {n,z,c,v}.
  - the EX/MEM control struct typedef.
- alu_64 imports the same package.
- One sub-module, nzcv_reg: the flag register plus the C/V clearing and the bypass mux. The pipeline register itself stays in ex_mem_stage.

## Test plan
- ADDS, A=B=64'h8000000000000000, ALU result 0, flags N0 Z1 C1 V1 -> br_* = 0,1,1,1 same cycle; flag_* = 0,1,1,1 after the edge; mem_result=0.
- ANDS with ALU flags N1 Z0 C1 V1 (C/V garbage) -> flag_* = 1,0,0,0.
- Plain ADD (set_flags=0), result 64'h000080001A000000, rd=3, reg_write=1 -> mem_result matches one cycle later, mem_reg_write=1, NZCV unchanged, br_* = flag_*.
- SUBS 1-1 with stall held 3 cycles -> NZCV unchanged for all 3 edges and br_* = 0,1,1,0 throughout; on release, flag_* = 0,1,1,0 and mem_valid=1.
- flush=1 and stall=1 with a valid STUR in EX -> mem_valid=0, mem_mem_write=0, NZCV unchanged.
- Assert reset mid-stream between edges -> all outputs 0 immediately; first post-reset capture behaves normally.
